// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control sequencer.
// Optional illegal-funct detection is enabled by defining ALUCTRL_ILLEGAL_EN.
package alu_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Default ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b110;

    // True when the low w bits of op are all ones (R-type escape)
    function automatic logic f_is_escape(input logic [31:0] op, input int unsigned w);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i < w) && !op[i]) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_control_seq_decode.sv
// Combinational ALUOp/Funct decode with resize to CTR_W.
// With ALUCTRL_ILLEGAL_EN defined, also flags escaped funct values not in LEGAL_MASK.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int FUNCT_W = 3,
    parameter int CTR_W   = 3
`ifdef ALUCTRL_ILLEGAL_EN
    ,
    parameter logic [(1<<FUNCT_W)-1:0] LEGAL_MASK = 8'b1011_1111
`endif
) (
    input  logic [OP_W-1:0]    i_alu_op,
    input  logic [FUNCT_W-1:0] i_funct,
`ifdef ALUCTRL_ILLEGAL_EN
    output logic               o_illegal,
`endif
    output logic [CTR_W-1:0]   o_dec
);

    localparam int PW0 = (OP_W > FUNCT_W) ? OP_W : FUNCT_W;
    localparam int PW  = (PW0 > CTR_W) ? PW0 : CTR_W;

    logic          w_esc;
    logic [PW-1:0] w_op_ext;
    logic [PW-1:0] w_funct_ext;

    assign w_esc       = f_is_escape(32'(i_alu_op), OP_W);
    assign w_op_ext    = PW'(i_alu_op);
    assign w_funct_ext = PW'(i_funct);

    // Select funct on escape, then zero-extend or truncate to the control width
    always_comb begin
        o_dec = CTR_W'(w_esc ? w_funct_ext : w_op_ext);
    end

`ifdef ALUCTRL_ILLEGAL_EN
    assign o_illegal = w_esc && !LEGAL_MASK[i_funct];
`endif

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a multi-cycle operation sequencer.
// One control code (MC_CODE) holds the ALU busy for MC_LAT cycles with stall.
// Optional feature: ALUCTRL_ILLEGAL_EN adds the registered illegal output.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int               OP_W    = 3,
    parameter int               FUNCT_W = 3,
    parameter int               CTR_W   = 3,
    parameter logic [CTR_W-1:0] MC_CODE = 3'b110,
    parameter int               MC_LAT  = 4
`ifdef ALUCTRL_ILLEGAL_EN
    ,
    parameter logic [(1<<FUNCT_W)-1:0] LEGAL_MASK = 8'b1011_1111
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTR_W-1:0]   alu_ctr,
    output logic               ctr_valid,
    output logic               stall,
`ifdef ALUCTRL_ILLEGAL_EN
    output logic               illegal,
`endif
    output logic               mc_done
);

    localparam int CNT_W = $clog2(MC_LAT + 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CTR_W-1:0] r_ctr, w_ctr_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_ill, w_ill_nxt;
    logic [CTR_W-1:0] w_dec;
    logic             w_ill;

`ifdef ALUCTRL_ILLEGAL_EN
    alu_ctrl_decode #(
        .OP_W       (OP_W),
        .FUNCT_W    (FUNCT_W),
        .CTR_W      (CTR_W),
        .LEGAL_MASK (LEGAL_MASK)
    ) u_decode (
        .i_alu_op  (alu_op),
        .i_funct   (funct),
        .o_illegal (w_ill),
        .o_dec     (w_dec)
    );
`else
    alu_ctrl_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W),
        .CTR_W   (CTR_W)
    ) u_decode (
        .i_alu_op (alu_op),
        .i_funct  (funct),
        .o_dec    (w_dec)
    );
    assign w_ill = 1'b0;
`endif

    // Next-state: accept in IDLE, count down busy cycles in BUSY (inputs ignored)
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ctr_nxt   = r_ctr;
        w_vld_nxt   = 1'b0;
        w_ill_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_vld_nxt = 1'b1;
                    w_ill_nxt = w_ill;
                    w_ctr_nxt = w_ill ? '0 : w_dec;
                    if (!w_ill && (w_dec == MC_CODE)) begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = CNT_W'(MC_LAT - 1);
                    end
                end
            end
            BUSY: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ctr   <= '0;
            r_vld   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ctr   <= w_ctr_nxt;
            r_vld   <= w_vld_nxt;
            r_ill   <= w_ill_nxt;
        end
    end

    assign alu_ctr   = r_ctr;
    assign ctr_valid = r_vld;
    assign stall     = (r_state == BUSY);
    assign mc_done   = (r_state == BUSY) && (r_cnt == '0);
`ifdef ALUCTRL_ILLEGAL_EN
    assign illegal   = r_ill;
`endif

    logic w_unused;
    assign w_unused = r_ill;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq (default MC_LAT=4 plus an MC_LAT=1 instance).
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [2:0] alu_op;
    logic [2:0] funct;
    logic [2:0] alu_ctr;
    logic       ctr_valid, stall, mc_done;
    logic [2:0] alu_ctr1;
    logic       ctr_valid1, stall1, mc_done1;
`ifdef ALUCTRL_ILLEGAL_EN
    logic       illegal, illegal1;
    localparam logic [2:0] MC_OP = 3'b110;
    localparam logic [2:0] MC_F  = 3'b000;
`else
    localparam logic [2:0] MC_OP = 3'b111;
    localparam logic [2:0] MC_F  = 3'b110;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    alu_control_seq dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op), .funct(funct),
        .alu_ctr(alu_ctr), .ctr_valid(ctr_valid), .stall(stall),
`ifdef ALUCTRL_ILLEGAL_EN
        .illegal(illegal),
`endif
        .mc_done(mc_done)
    );

    alu_control_seq #(.MC_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op), .funct(funct),
        .alu_ctr(alu_ctr1), .ctr_valid(ctr_valid1), .stall(stall1),
`ifdef ALUCTRL_ILLEGAL_EN
        .illegal(illegal1),
`endif
        .mc_done(mc_done1)
    );

    // Scoreboard: every ctr_valid pulse of the main DUT must match the oldest pushed expectation
    always @(negedge clk) begin
        if (!reset && ctr_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected ctr_valid, alu_ctr=%b, no expectation queued", alu_ctr);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (alu_ctr !== e) begin
                    errors++;
                    $display("FAIL scoreboard: alu_ctr=%b expected %b", alu_ctr, e);
                end
            end
        end
    end

    function automatic logic [2:0] exp_dec(input logic [2:0] op, input logic [2:0] f);
        logic [7:0] mask;
        mask = 8'b1011_1111;
        if (op == 3'b111) begin
`ifdef ALUCTRL_ILLEGAL_EN
            if (!mask[f]) return 3'b000;
`endif
            return f;
        end
        return op;
    endfunction

    // Drive inputs for the next edge; queue the expected result when it will be accepted
    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f, input logic acc);
        valid_in = v;
        alu_op   = op;
        funct    = f;
        if (acc) exp_q.push_back(exp_dec(op, f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 3'b000, 3'b000, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        tick();
        tick();
        checks++;
        if ({alu_ctr, ctr_valid, stall, mc_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset: ctr=%b vld=%b stall=%b done=%b expected all 0",
                     alu_ctr, ctr_valid, stall, mc_done);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        drive(1'b1, 3'b010, 3'b101, 1'b1);
        tick();
        checks++;
        if (ctr_valid !== 1'b1 || alu_ctr !== 3'b010 || stall !== 1'b0) begin
            errors++;
            $display("FAIL single_add: vld=%b ctr=%b stall=%b expected 1 010 0", ctr_valid, alu_ctr, stall);
        end
        drive(1'b1, 3'b111, 3'b011, 1'b1);
        tick();
        checks++;
        if (ctr_valid !== 1'b1 || alu_ctr !== 3'b011 || stall !== 1'b0) begin
            errors++;
            $display("FAIL single_rtype: vld=%b ctr=%b stall=%b expected 1 011 0", ctr_valid, alu_ctr, stall);
        end
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        tick();
        checks++;
        if (ctr_valid !== 1'b0 || alu_ctr !== 3'b011) begin
            errors++;
            $display("FAIL idle_hold: vld=%b ctr=%b expected 0 011", ctr_valid, alu_ctr);
        end
    endtask

    task automatic test_multicycle();
        drive(1'b1, MC_OP, MC_F, 1'b1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (stall !== 1'b1 || mc_done !== (k == 4) || alu_ctr !== 3'b110 || ctr_valid !== (k == 1)) begin
                errors++;
                $display("FAIL mc_busy[%0d]: stall=%b done=%b ctr=%b vld=%b expected 1 %b 110 %b",
                         k, stall, mc_done, alu_ctr, ctr_valid, (k == 4), (k == 1));
            end
            drive(1'b1, 3'(k - 1), 3'b001, 1'b0);
            tick();
        end
        checks++;
        if (stall !== 1'b0 || mc_done !== 1'b0 || ctr_valid !== 1'b0 || alu_ctr !== 3'b110) begin
            errors++;
            $display("FAIL mc_release: stall=%b done=%b vld=%b ctr=%b expected 0 0 0 110",
                     stall, mc_done, ctr_valid, alu_ctr);
        end
        drive(1'b1, 3'b001, 3'b000, 1'b1);
        tick();
        checks++;
        if (ctr_valid !== 1'b1 || alu_ctr !== 3'b001 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mc_next_accept: vld=%b ctr=%b stall=%b expected 1 001 0", ctr_valid, alu_ctr, stall);
        end
        idle(1);
    endtask

    task automatic test_reset_abort();
        drive(1'b1, MC_OP, MC_F, 1'b1);
        tick();
        idle(1);
        reset = 1'b1;
        tick();
        checks++;
        if (stall !== 1'b0 || mc_done !== 1'b0 || alu_ctr !== 3'b000 || ctr_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort: stall=%b done=%b ctr=%b vld=%b expected 0 0 000 0",
                     stall, mc_done, alu_ctr, ctr_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (mc_done !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL abort_after[%0d]: done=%b stall=%b expected 0 0", i, mc_done, stall);
            end
        end
    endtask

    task automatic test_mc_lat1();
        drive(1'b1, MC_OP, MC_F, 1'b1);
        tick();
        checks++;
        if (stall1 !== 1'b1 || mc_done1 !== 1'b1 || alu_ctr1 !== 3'b110) begin
            errors++;
            $display("FAIL lat1_busy: stall=%b done=%b ctr=%b expected 1 1 110", stall1, mc_done1, alu_ctr1);
        end
        idle(1);
        checks++;
        if (stall1 !== 1'b0 || mc_done1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_release: stall=%b done=%b expected 0 0", stall1, mc_done1);
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 3'b111, 1'b1);
            tick();
            checks++;
            if (ctr_valid !== 1'b1 || alu_ctr !== 3'(i) || stall !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d]: vld=%b ctr=%b stall=%b expected 1 %b 0", i, ctr_valid, alu_ctr, stall, 3'(i));
            end
        end
        idle(1);
    endtask

`ifdef ALUCTRL_ILLEGAL_EN
    task automatic test_illegal();
        drive(1'b1, 3'b111, 3'b110, 1'b1);
        tick();
        checks++;
        if (illegal !== 1'b1 || alu_ctr !== 3'b000 || ctr_valid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL illegal: ill=%b ctr=%b vld=%b stall=%b expected 1 000 1 0",
                     illegal, alu_ctr, ctr_valid, stall);
        end
        idle(1);
        checks++;
        if (stall !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after: stall=%b ill=%b expected 0 0", stall, illegal);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        alu_op   = 3'b000;
        funct    = 3'b000;
        test_reset();
        test_single();
        test_multicycle();
        test_reset_abort();
        test_mc_lat1();
        test_back_to_back();
`ifdef ALUCTRL_ILLEGAL_EN
        test_illegal();
`endif
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
